// File: rtl/counter_pkg.sv
// Shared encodings for the counter sequencer: command opcodes, FSM states and reset defaults.
package counter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_PRE_W = 8;

    // Target resets to all ones so a bare START from reset runs to the top of the range.
    localparam logic [DEF_WIDTH-1:0] PRESET_RST = '0;
    localparam logic [DEF_WIDTH-1:0] TARGET_RST = '1;

    typedef enum logic [1:0] {
        OP_SET_PRESET = 2'b00,
        OP_SET_TARGET = 2'b01,
        OP_START      = 2'b10,
        OP_STOP       = 2'b11
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRELOAD = 2'b01,
        ST_RUN     = 2'b10,
        ST_DONE    = 2'b11
    } seq_state_t;

    function automatic logic is_active(input seq_state_t s);
        return (s == ST_PRELOAD) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/counter_sequencer_if.sv
// Command port of the counter sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the master holds cmd_op/cmd_data stable while cmd_valid is high and not yet accepted.
interface counter_sequencer_if
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    cmd_op_t          cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/counter_sequencer_tick_divider.sv
// Prescaler: while run is high, tick pulses once every period+1 cycles; clear restarts the phase.
module tick_divider #(
    parameter int PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [PRE_W-1:0] period,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick = run && (pre_cnt_q == period);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clear || tick) begin
            pre_cnt_d = '0;
        end else if (run) begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Control stage for an 8-bit loadable up-counter: command decode, prescaled ticks,
// shadow count with target compare, one-shot or auto-reload runs.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_sequencer_if.slave  cmd,
    input  logic [PRE_W-1:0]    prescale,
    input  logic                auto_reload,
    input  logic                out_req,
    output logic                load,
    output logic [WIDTH-1:0]    load_value,
    output logic                enable,
    output logic                oe,
    output logic                busy,
    output logic                done,
    output seq_state_t          dbg_state
);

    localparam logic [WIDTH-1:0] PRESET_INIT = {WIDTH{PRESET_RST[0]}};
    localparam logic [WIDTH-1:0] TARGET_INIT = {WIDTH{TARGET_RST[0]}};

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [WIDTH-1:0] preset_q;
    logic [WIDTH-1:0] preset_d;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] target_d;
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] shadow_d;
    logic [WIDTH-1:0] load_value_q;
    logic [WIDTH-1:0] load_value_d;
    logic [PRE_W-1:0] prescale_q;
    logic [PRE_W-1:0] prescale_d;
    logic             auto_reload_q;
    logic             auto_reload_d;
    logic             load_q;
    logic             load_d;
    logic             enable_q;
    logic             enable_d;
    logic             done_q;
    logic             done_d;
    logic             busy_q;
    logic             busy_d;

    logic             cmd_ready;
    logic             cmd_acc;
    logic             start_acc;
    logic             stop_acc;
    logic             set_preset_acc;
    logic             set_target_acc;
    logic             running;
    logic             div_tick;
    logic             tick;
    logic             hit;
    logic [WIDTH-1:0] shadow_inc;

    // ---------------- command decode ----------------
    assign cmd_ready      = (state_q != ST_PRELOAD);
    assign cmd.cmd_ready  = cmd_ready;
    assign cmd_acc        = cmd.cmd_valid && cmd_ready;
    assign start_acc      = cmd_acc && (cmd.cmd_op == OP_START);
    assign stop_acc       = cmd_acc && (cmd.cmd_op == OP_STOP);
    assign set_preset_acc = cmd_acc && (cmd.cmd_op == OP_SET_PRESET);
    assign set_target_acc = cmd_acc && (cmd.cmd_op == OP_SET_TARGET);

    assign preset_d = set_preset_acc ? cmd.cmd_data : preset_q;
    assign target_d = set_target_acc ? cmd.cmd_data : target_q;

    // ---------------- prescaler and shadow compare ----------------
    // The divider already runs in PRELOAD so that, with prescale=0, the first
    // enable lands on the very first RUN cycle.
    assign running = is_active(state_q);

    tick_divider #(
        .PRE_W (PRE_W)
    ) u_tick_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (start_acc || stop_acc),
        .run    (running),
        .period (prescale_q),
        .tick   (div_tick)
    );

    // A START/STOP accepted on a tick cycle swallows that tick entirely.
    assign tick       = div_tick && !start_acc && !stop_acc;
    assign shadow_inc = shadow_q + WIDTH'(1);
    assign hit        = tick && (shadow_inc == target_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_PRELOAD;
                end
            end
            ST_PRELOAD, ST_RUN: begin
                state_d = ST_RUN;
                if (stop_acc) begin
                    state_d = ST_IDLE;
                end else if (start_acc) begin
                    state_d = ST_PRELOAD;
                end else if (hit) begin
                    state_d = auto_reload_q ? ST_PRELOAD : ST_DONE;
                end
            end
            ST_DONE: begin
                if (stop_acc) begin
                    state_d = ST_IDLE;
                end else if (start_acc) begin
                    state_d = ST_PRELOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        load_d        = 1'b0;
        load_value_d  = load_value_q;
        enable_d      = tick;
        done_d        = hit;
        shadow_d      = tick ? shadow_inc : shadow_q;
        prescale_d    = prescale_q;
        auto_reload_d = auto_reload_q;
        busy_d        = is_active(state_d);

        if (start_acc) begin
            prescale_d    = prescale;
            auto_reload_d = auto_reload;
        end

        // Entering PRELOAD (fresh start, restart or auto-reload) loads the preset.
        if (state_d == ST_PRELOAD) begin
            load_d       = 1'b1;
            load_value_d = preset_q;
            shadow_d     = preset_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            preset_q      <= PRESET_INIT;
            target_q      <= TARGET_INIT;
            shadow_q      <= '0;
            load_value_q  <= '0;
            prescale_q    <= '0;
            auto_reload_q <= 1'b0;
            load_q        <= 1'b0;
            enable_q      <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            preset_q      <= preset_d;
            target_q      <= target_d;
            shadow_q      <= shadow_d;
            load_value_q  <= load_value_d;
            prescale_q    <= prescale_d;
            auto_reload_q <= auto_reload_d;
            load_q        <= load_d;
            enable_q      <= enable_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
        end
    end

    assign load       = load_q;
    assign load_value = load_value_q;
    assign enable     = enable_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign oe         = out_req || (state_q != ST_IDLE);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: table of one-shot runs plus hand-written corner sequences,
// with a scoreboard of expected load values and tick counts checked by a monitor.
module tb_counter_sequencer;
  import counter_pkg::*;

  localparam int W  = 8;
  localparam int PW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [PW-1:0] prescale;
  logic          auto_reload;
  logic          out_req;
  logic          load;
  logic [W-1:0]  load_value;
  logic          enable;
  logic          oe;
  logic          busy;
  logic          done;
  seq_state_t    dbg_state;

  counter_sequencer_if #(.WIDTH(W)) cmd_if ();

  counter_sequencer #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .prescale    (prescale),
    .auto_reload (auto_reload),
    .out_req     (out_req),
    .load        (load),
    .load_value  (load_value),
    .enable      (enable),
    .oe          (oe),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Downstream counter driven by the sequencer (load has priority over enable).
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (load) cnt_q <= load_value;
    else if (enable) cnt_q <= cnt_q + W'(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];       // expected load_value per load pulse
  logic [8:0]   done_exp_q[$];  // expected ticks from load to done
  int cur_ps = 0;
  int since_load = 0;
  int ticks_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    checks++;
    failures++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  // Monitor: tick phase relative to the last load, load_value and done tick count.
  always @(negedge clk) begin
    if (rst_n) begin
      since_load++;
      if (enable) begin
        ticks_run++;
        check("tick_phase", 32'(since_load), 32'(ticks_run * (cur_ps + 1)));
      end
      if (done) begin
        check("done_with_enable", 32'(enable), 32'd1);
        if (done_exp_q.size() == 0) fail_now("done_unexpected", "done pulse with no pending run");
        else check("done_ticks", 32'(ticks_run), 32'(done_exp_q.pop_front()));
      end
      if (load) begin
        if (exp_q.size() == 0) fail_now("load_unexpected", "load pulse with no pending start");
        else check("load_value", 32'(load_value), 32'(exp_q.pop_front()));
        since_load = 0;
        ticks_run = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send_cmd(input cmd_op_t op, input logic [W-1:0] data, output int stalls);
    stalls = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op = op;
    cmd_if.cmd_data = data;
    while (!cmd_if.cmd_ready && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (!cmd_if.cmd_ready) begin
      fail_now("cmd_accept_timeout", "cmd_ready never rose");
      cmd_if.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    bit found = 0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done) found = 1;
    end
    if (!found) fail_now("done_timeout", "no done within cycle budget");
  endtask

  task automatic start_run(input logic [PW-1:0] ps, input logic ar, input logic [W-1:0] exp_load);
    int st;
    prescale = ps;
    auto_reload = ar;
    cur_ps = int'(ps);
    exp_q.push_back(exp_load);
    send_cmd(OP_START, '0, st);
    check("load_after_start", 32'(load), 32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [W-1:0]  preset;
    logic [W-1:0]  target;
    logic [PW-1:0] ps;
    logic [8:0]    exp_ticks;
    logic [W-1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int st;
    vecs[0] = '{preset: 8'h03, target: 8'h06, ps: 8'd0, exp_ticks: 9'd3,   exp_cnt: 8'h06};
    vecs[1] = '{preset: 8'h00, target: 8'h02, ps: 8'd4, exp_ticks: 9'd2,   exp_cnt: 8'h02};
    vecs[2] = '{preset: 8'hFE, target: 8'h01, ps: 8'd1, exp_ticks: 9'd3,   exp_cnt: 8'h01};
    vecs[3] = '{preset: 8'h10, target: 8'h10, ps: 8'd0, exp_ticks: 9'd256, exp_cnt: 8'h10};
    vecs[4] = '{preset: 8'h80, target: 8'h85, ps: 8'd2, exp_ticks: 9'd5,   exp_cnt: 8'h85};
    vecs[5] = '{preset: 8'hFF, target: 8'h00, ps: 8'd3, exp_ticks: 9'd1,   exp_cnt: 8'h00};

    rst_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op = OP_STOP;
    cmd_if.cmd_data = '0;
    prescale = '0;
    auto_reload = 1'b0;
    out_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_load", 32'(load), 32'd0);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_load_value", 32'(load_value), 32'd0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    out_req = 1'b1;
    #1 check("idle_oe_out_req", 32'(oe), 32'd1);
    out_req = 1'b0;
    @(negedge clk);
    send_cmd(OP_STOP, '0, st);
    check("idle_stop_noop", 32'(dbg_state), 32'(ST_IDLE));

    // Table: one-shot runs
    for (int i = 0; i < 6; i++) begin
      send_cmd(OP_SET_PRESET, vecs[i].preset, st);
      send_cmd(OP_SET_TARGET, vecs[i].target, st);
      done_exp_q.push_back(vecs[i].exp_ticks);
      start_run(vecs[i].ps, 1'b0, vecs[i].preset);
      check("preload_busy", 32'(busy), 32'd1);
      check("preload_ready", 32'(cmd_if.cmd_ready), 32'd0);
      @(negedge clk);
      check("run_ready", 32'(cmd_if.cmd_ready), 32'd1);
      wait_done((int'(vecs[i].exp_ticks) + 1) * (int'(vecs[i].ps) + 1) + 20);
      @(negedge clk);
      check("final_cnt", 32'(cnt_q), 32'(vecs[i].exp_cnt));
      check("done_state", 32'(dbg_state), 32'(ST_DONE));
      check("done_oe", 32'(oe), 32'd1);
      check("done_enable_low", 32'(enable), 32'd0);
      check("done_busy_low", 32'(busy), 32'd0);
      send_cmd(OP_STOP, '0, st);
      check("stop_state", 32'(dbg_state), 32'(ST_IDLE));
      check("stop_oe", 32'(oe), 32'd0);
    end

    // Auto-reload across the wrap: FF, 00, 01 then reload FE, three times
    send_cmd(OP_SET_PRESET, 8'hFE, st);
    send_cmd(OP_SET_TARGET, 8'h01, st);
    repeat (3) exp_q.push_back(8'hFE);
    repeat (3) done_exp_q.push_back(9'd3);
    start_run(8'd0, 1'b1, 8'hFE);
    for (int r = 0; r < 3; r++) begin
      wait_done(20);
      check("ar_wrap_cnt", 32'(cnt_q), 32'h00);
      check("ar_reload_load", 32'(load), 32'd1);
      check("ar_reload_value", 32'(load_value), 32'hFE);
    end
    check("ar_preload_ready", 32'(cmd_if.cmd_ready), 32'd0);
    send_cmd(OP_STOP, '0, st);
    check("ar_stop_stall", 32'(st), 32'd1);
    check("ar_stop_state", 32'(dbg_state), 32'(ST_IDLE));

    // STOP accepted on the target tick: no enable, no done
    out_req = 1'b1;
    send_cmd(OP_SET_PRESET, 8'h00, st);
    send_cmd(OP_SET_TARGET, 8'h03, st);
    start_run(8'd2, 1'b0, 8'h00);
    repeat (8) @(negedge clk);
    send_cmd(OP_STOP, '0, st);
    check("coll_enable", 32'(enable), 32'd0);
    check("coll_done", 32'(done), 32'd0);
    check("coll_state", 32'(dbg_state), 32'(ST_IDLE));
    check("coll_oe_req", 32'(oe), 32'd1);
    check("coll_cnt", 32'(cnt_q), 32'h02);
    out_req = 1'b0;
    #1 check("coll_oe_noreq", 32'(oe), 32'd0);
    repeat (6) @(negedge clk);

    // SET_TARGET in RUN moves the stop point
    send_cmd(OP_SET_TARGET, 8'h40, st);
    done_exp_q.push_back(9'd3);
    start_run(8'd3, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    send_cmd(OP_SET_TARGET, 8'h03, st);
    wait_done(40);
    @(negedge clk);
    check("newtgt_cnt", 32'(cnt_q), 32'h03);
    send_cmd(OP_STOP, '0, st);

    // SET_TARGET on the tick cycle: compare still uses the old target
    send_cmd(OP_SET_TARGET, 8'h01, st);
    done_exp_q.push_back(9'd1);
    start_run(8'd1, 1'b0, 8'h00);
    @(negedge clk);
    send_cmd(OP_SET_TARGET, 8'h05, st);
    check("tick_settgt_done", 32'(done), 32'd1);
    @(negedge clk);
    done_exp_q.push_back(9'd5);
    start_run(8'd1, 1'b0, 8'h00);
    wait_done(30);
    @(negedge clk);
    check("tick_settgt_cnt", 32'(cnt_q), 32'h05);
    send_cmd(OP_STOP, '0, st);

    // Asynchronous reset mid-run
    send_cmd(OP_SET_PRESET, 8'h05, st);
    send_cmd(OP_SET_TARGET, 8'hF0, st);
    done_exp_q.push_back(9'd235);
    start_run(8'd0, 1'b0, 8'h05);
    repeat (4) @(negedge clk);
    check("midrun_enable", 32'(enable), 32'd1);
    out_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_load", 32'(load), 32'd0);
    check("arst_enable", 32'(enable), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_oe_req", 32'(oe), 32'd1);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    out_req = 1'b0;
    #1 check("arst_oe_noreq", 32'(oe), 32'd0);
    exp_q.delete();
    done_exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_exp_q.push_back(9'(TARGET_RST));
    start_run(8'd0, 1'b0, 8'h00);
    check("post_rst_load_value", 32'(load_value), 32'h00);
    wait_done(300);
    @(negedge clk);
    check("post_rst_cnt", 32'(cnt_q), 32'(TARGET_RST));
    send_cmd(OP_STOP, '0, st);

    repeat (4) @(negedge clk);
    check("load_queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_queue_drained", 32'(done_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
